// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the execute-stage divide sequencer: state encoding,
// divide-by-zero quotient and the ALU control codes that start a divide.
package div_sequencer_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 5;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    localparam logic [DIV_WIDTH-1:0] DIV0_QUO = '1;

    // The controller decodes these into startE/signedE.
    localparam logic [3:0] ALU_DIV  = 4'b1100;
    localparam logic [3:0] ALU_DIVU = 4'b1101;

endpackage

// File: rtl/div_sequencer_step.sv
// One combinational restoring-division iteration: shift {rem,quo} left by one,
// subtract the divisor and keep the difference when it is non-negative.
module div_sequencer_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_n,
    output logic [WIDTH-1:0] quo_n
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial;
    logic           trial_ok;

    // A set top bit of the shifted remainder means it already exceeds any divisor.
    always_comb begin
        rem_sh   = {rem, quo[WIDTH-1]};
        trial    = rem_sh - {1'b0, divisor};
        trial_ok = rem_sh[WIDTH] | ~trial[WIDTH];
        if (trial_ok) begin
            rem_n = trial[WIDTH-1:0];
            quo_n = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_n = rem_sh[WIDTH-1:0];
            quo_n = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_sequencer.sv
// Sequences a WIDTH-cycle radix-2 restoring divider for DIV/DIVU in the execute
// stage, stalling the pipeline while busy and producing HI (remainder) / LO (quotient).
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             startE,
    input  logic             signedE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             cancel,
    output logic             stallE,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH-1:0] rem_n, quo_n;
    logic             a_neg, b_neg, div_zero, last_step;

    assign a_neg     = signedE & srcaE[WIDTH-1];
    assign b_neg     = signedE & srcbE[WIDTH-1];
    assign div_zero  = (srcbE == '0);
    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));
    assign hi_o      = hi_q;
    assign lo_o      = lo_q;

    div_sequencer_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem_q),
        .quo     (quo_q),
        .divisor (dvs_q),
        .rem_n   (rem_n),
        .quo_n   (quo_n)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DIV_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (cancel) begin
            state_d = DIV_IDLE;
        end else begin
            case (state_q)
                DIV_IDLE: if (startE) state_d = div_zero ? DIV_DONE : DIV_RUN;
                DIV_RUN:  if (last_step) state_d = DIV_DONE;
                DIV_DONE: state_d = DIV_IDLE;
                default:  state_d = DIV_IDLE;
            endcase
        end
    end

    always_comb begin
        busy   = (state_q != DIV_IDLE);
        done   = (state_q == DIV_DONE) && !cancel;
        stallE = !cancel && (((state_q == DIV_IDLE) && startE) || (state_q == DIV_RUN));
    end

    // Operands are divided as magnitudes; the quotient/remainder signs are restored on the final step.
    always_comb begin
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (!cancel) begin
            case (state_q)
                DIV_IDLE: begin
                    if (startE) begin
                        cnt_d     = '0;
                        rem_d     = '0;
                        quo_d     = a_neg ? -srcaE : srcaE;
                        dvs_d     = b_neg ? -srcbE : srcbE;
                        neg_quo_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        if (div_zero) begin
                            lo_d = DIV0_QUO;
                            hi_d = srcaE;
                        end
                    end
                end
                DIV_RUN: begin
                    rem_d = rem_n;
                    quo_d = quo_n;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_step) begin
                        lo_d = neg_quo_q ? -quo_n : quo_n;
                        hi_d = neg_rem_q ? -rem_n : rem_n;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: expected quotient/remainder come from a
// behavioural divide model and are compared whenever the DUT pulses done.
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        startE = 1'b0;
    logic        signedE = 1'b0;
    logic        cancel = 1'b0;
    logic [31:0] srcaE = '0;
    logic [31:0] srcbE = '0;
    logic        stallE, busy, done;
    logic [31:0] hi_o, lo_o;

    int passCnt = 0;
    int checkCnt = 0;
    int cycleCnt = 0;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
    } exp_t;

    exp_t        sbq[$];
    exp_t        monE;
    logic [31:0] lastLo = '0;
    logic [31:0] lastHi = '0;

    div_sequencer dut (
        .clk     (clk),
        .rst     (rst),
        .startE  (startE),
        .signedE (signedE),
        .srcaE   (srcaE),
        .srcbE   (srcbE),
        .cancel  (cancel),
        .stallE  (stallE),
        .busy    (busy),
        .done    (done),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCnt++;
        if (obs !== exp)
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        else
            passCnt++;
    endtask

    function automatic exp_t model(input logic s, input logic [31:0] a, input logic [31:0] b);
        exp_t r;
        if (b == 32'd0) begin
            r.lo = 32'hFFFF_FFFF;
            r.hi = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r.lo = 32'h8000_0000;
            r.hi = 32'd0;
        end else if (s) begin
            r.lo = $signed(a) / $signed(b);
            r.hi = $signed(a) % $signed(b);
        end else begin
            r.lo = a / b;
            r.hi = a % b;
        end
        return r;
    endfunction

    // Every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && done) begin
            if (sbq.size() == 0) begin
                checkOutput("spurious_done", {31'b0, done}, 32'd0);
            end else begin
                monE = sbq.pop_front();
                checkOutput("lo_o", lo_o, monE.lo);
                checkOutput("hi_o", hi_o, monE.hi);
                lastLo = monE.lo;
                lastHi = monE.hi;
            end
        end
    end

    // Called at posedge+1; holds startE until done, then drops it one edge later.
    task automatic applyStimulus(input logic s, input logic [31:0] a, input logic [31:0] b,
                                 input int expLat, output int doneAbs);
        int cyc, stallCnt, startCyc, lat;
        sbq.push_back(model(s, a, b));
        startCyc = cycleCnt;
        startE   = 1'b1;
        signedE  = s;
        srcaE    = a;
        srcbE    = b;
        cyc      = 0;
        stallCnt = 0;
        doneAbs  = -1;
        lat      = -1;
        while (cyc < 200) begin
            @(negedge clk);
            if (done) begin
                doneAbs = cycleCnt;
                lat     = cycleCnt - startCyc;
                break;
            end
            if (stallE) stallCnt++;
            cyc++;
            @(posedge clk); #1;
        end
        checkOutput("latency", 32'(lat), 32'(expLat));
        checkOutput("stall_cycles", 32'(stallCnt), 32'(expLat));
        @(posedge clk); #1;
        startE = 1'b0;
    endtask

    initial begin
        int d1, d2, base;
        logic s;
        logic [31:0] a, b;

        #1 rst = 1'b0;
        #10;
        checkOutput("rst_hi", hi_o, 32'd0);
        checkOutput("rst_lo", lo_o, 32'd0);
        checkOutput("rst_done", {31'b0, done}, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_stall", {31'b0, stallE}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        applyStimulus(1'b0, 32'd100, 32'd7, 33, d1);
        checkOutput("divu100_7_lo", lo_o, 32'd14);
        checkOutput("divu100_7_hi", hi_o, 32'd2);
        applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2, 33, d1);
        checkOutput("div_m7_2_lo", lo_o, 32'hFFFF_FFFD);
        checkOutput("div_m7_2_hi", hi_o, 32'hFFFF_FFFF);
        applyStimulus(1'b1, 32'd7, 32'hFFFF_FFFE, 33, d1);
        applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, d1);
        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd1, 33, d1);
        applyStimulus(1'b0, 32'd5, 32'd0, 1, d1);
        applyStimulus(1'b1, 32'hFFFF_FFFB, 32'd0, 1, d1);
        checkOutput("div_m5_0_hi", hi_o, 32'hFFFF_FFFB);

        // Cancel in the tenth RUN cycle.
        startE  = 1'b1;
        signedE = 1'b0;
        srcaE   = 32'd1000;
        srcbE   = 32'd3;
        repeat (10) @(posedge clk);
        #1 cancel = 1'b1;
        @(negedge clk);
        checkOutput("cancel_stall", {31'b0, stallE}, 32'd0);
        checkOutput("cancel_done", {31'b0, done}, 32'd0);
        @(posedge clk); #1;
        cancel = 1'b0;
        startE = 1'b0;
        @(negedge clk);
        checkOutput("cancel_busy", {31'b0, busy}, 32'd0);
        checkOutput("cancel_lo_kept", lo_o, lastLo);
        checkOutput("cancel_hi_kept", hi_o, lastHi);
        @(posedge clk); #1;
        applyStimulus(1'b0, 32'd9, 32'd3, 33, d1);

        // Cancel arriving together with done.
        startE  = 1'b1;
        signedE = 1'b0;
        srcaE   = 32'd11;
        srcbE   = 32'd0;
        @(posedge clk); #1;
        cancel = 1'b1;
        startE = 1'b0;
        @(negedge clk);
        checkOutput("cancel_done_state", {31'b0, done}, 32'd0);
        @(posedge clk); #1;
        cancel = 1'b0;
        @(negedge clk);
        checkOutput("cancel_done_busy", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;

        base = cycleCnt;
        applyStimulus(1'b0, 32'd20, 32'd6, 33, d1);
        applyStimulus(1'b0, 32'd8, 32'd8, 33, d2);
        checkOutput("b2b_first_done", 32'(d1 - base), 32'd33);
        checkOutput("b2b_second_done", 32'(d2 - base), 32'd67);

        for (int i = 0; i < 4; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            applyStimulus(s, a, b, (b == 32'd0) ? 1 : 33, d1);
        end

        // Reset asserted in the middle of a divide.
        startE  = 1'b1;
        signedE = 1'b0;
        srcaE   = 32'd12345;
        srcbE   = 32'd17;
        repeat (15) @(posedge clk);
        #2;
        rst    = 1'b0;
        startE = 1'b0;
        #1;
        checkOutput("midrst_hi", hi_o, 32'd0);
        checkOutput("midrst_lo", lo_o, 32'd0);
        checkOutput("midrst_done", {31'b0, done}, 32'd0);
        checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
        checkOutput("midrst_stall", {31'b0, stallE}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("post_rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("sb_empty", 32'(sbq.size()), 32'd0);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
